// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   // BOOT: one idle cycle after reset; REQ: request on the bus;
   // WAIT: request granted, awaiting the response; HOLD: instruction offered to decode.
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/npc_sel.sv
// Redirect priority and next-pc candidates for the fetch controller.
// A branch wins over a JAL when both are requested in the same cycle.
module npc_sel #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jal_taken,
   input  logic [ADDR_WIDTH-1:0] jal_target,
   output logic                  redirect,
   output logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] pc_plus4
);

   // Pick the redirect source and form the sequential successor (wraps at all-ones).
   always_comb begin
      redirect        = branch_taken | jal_taken;
      redirect_target = branch_taken ? branch_target : jal_target;
      pc_plus4        = pc + ADDR_WIDTH'(4);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request at a time,
// a single holding register toward decode, and redirect (branch/JAL) handling
// that can kill an in-flight fetch.
//
// Handshakes: a request transfers in a cycle where imem_req=1 and imem_gnt=1
// (imem_addr is held stable while imem_req=1 and no redirect arrives); the
// response is the single cycle with imem_rvalid=1 while in WAIT. Toward decode,
// instr/instr_pc are valid while instr_valid=1 and are consumed in a cycle with
// stall=0; they stay stable until then.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   input  logic                   jal_taken,
   input  logic [ADDR_WIDTH-1:0]  jal_target,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic                   fetch_clk_en,
   output fetch_state_t           state_dbg
);

   fetch_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
   logic                   instr_valid_q, instr_valid_d;
   logic                   kill_q, kill_d;

   logic                   redirect;
   logic [ADDR_WIDTH-1:0]  redirect_target;
   logic [ADDR_WIDTH-1:0]  pc_plus4;

   npc_sel #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_npc_sel (
      .pc              (pc_q),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .jal_taken       (jal_taken),
      .jal_target      (jal_target),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .pc_plus4        (pc_plus4)
   );

   // Next-state, next-pc and fetch-clock enable; redirects are ignored in BOOT.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      kill_d        = kill_q;
      imem_req      = 1'b0;
      fetch_clk_en  = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = REQ;
         end
         REQ: begin
            imem_req     = 1'b1;
            fetch_clk_en = 1'b1;
            if (redirect) pc_d = redirect_target;
            if (imem_gnt) begin
               // A redirect racing the grant leaves that fetch stale.
               state_d = WAIT;
               kill_d  = redirect;
            end
         end
         WAIT: begin
            fetch_clk_en = 1'b1;
            if (imem_rvalid) begin
               if (!kill_q && !redirect) begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end else begin
                  state_d = REQ;
               end
               kill_d = 1'b0;
               if (redirect) pc_d = redirect_target;
            end else if (redirect) begin
               // Response still owed by memory: remember to drop it.
               kill_d = 1'b1;
               pc_d   = redirect_target;
            end
         end
         HOLD: begin
            fetch_clk_en = !stall || redirect;
            if (redirect) begin
               pc_d          = redirect_target;
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end else if (!stall) begin
               pc_d          = pc_plus4;
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= BOOT;
         pc_q          <= RESET_ADDR;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         kill_q        <= kill_d;
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then a
// randomized phase against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int AW = 32;
   localparam logic [AW-1:0] RST_PC = '0;

   logic          clk;
   logic          reset_n;
   logic          stall;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          jal_taken;
   logic [AW-1:0] jal_target;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          instr_valid;
   logic [31:0]   instr;
   logic [AW-1:0] instr_pc;
   logic [AW-1:0] pc;
   logic          fetch_clk_en;
   fetch_state_t  state_dbg;

   fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_ADDR(RST_PC)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jal_taken(jal_taken), .jal_target(jal_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc(pc), .fetch_clk_en(fetch_clk_en), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters and scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- behavioural model ----------------
   // Transaction view: the stage is either booting, asking memory for m_pc,
   // waiting on an in-flight fetch (possibly dead), or holding one instruction.
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_ipc;
   logic [31:0]   m_instr;
   bit            m_boot, m_inflight, m_dead, m_have;
   int            consumed = 0;

   // ---------------- memory responder (random phase) ----------------
   bit            rand_mode = 0;
   bit            mem_busy = 0;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] grant_addr;
   int            mem_delay = 0;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc       = RST_PC;
      m_ipc      = '0;
      m_instr    = NOP_INSTR;
      m_boot     = 1;
      m_inflight = 0;
      m_dead     = 0;
      m_have     = 0;
      exp_q.delete();
   endtask

   // Apply one clock worth of events; reads only bench-driven inputs.
   task automatic model_advance();
      bit            redir;
      logic [AW-1:0] tgt;
      redir = (branch_taken || jal_taken) && !m_boot;
      tgt   = branch_taken ? branch_target : jal_target;
      if (m_boot) begin
         m_boot = 0;
      end else if (m_have) begin
         if (redir) begin
            m_have = 0;
            m_pc   = tgt;
         end else if (!stall) begin
            m_have = 0;
            m_pc   = m_pc + 32'd4;
            consumed++;
         end
      end else if (m_inflight) begin
         if (imem_rvalid) begin
            m_inflight = 0;
            if (!m_dead && !redir) begin
               m_have  = 1;
               m_instr = imem_rdata;
               m_ipc   = m_pc;
               exp_q.push_back(m_pc);
            end
            m_dead = 0;
            if (redir) m_pc = tgt;
         end else if (redir) begin
            m_dead = 1;
            m_pc   = tgt;
         end
      end else begin
         if (redir) m_pc = tgt;
         if (imem_gnt) begin
            m_inflight = 1;
            m_dead     = redir;
         end
      end
   endtask

   task automatic mem_track();
      if (imem_gnt) begin
         mem_busy  = 1;
         mem_addr  = grant_addr;
         mem_delay = $urandom_range(0, 3);
      end else if (mem_busy) begin
         if (imem_rvalid) mem_busy = 0;
         else mem_delay--;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) begin
         if (rand_mode) mem_track();
         model_advance();
      end
      @(negedge clk);
   endtask

   // ---------------- compare process ----------------
   bit prev_valid = 0;
   task automatic check_all();
      bit redir;
      bit exp_en;
      redir  = branch_taken || jal_taken;
      exp_en = !m_boot && (!m_have || !stall || redir);
      chk1("m_imem_req", imem_req, !m_boot && !m_inflight && !m_have);
      if (!m_boot && !m_inflight && !m_have) chk("m_imem_addr", imem_addr, m_pc);
      chk("m_pc", pc, m_pc);
      chk1("m_instr_valid", instr_valid, m_have);
      if (m_have) begin
         chk("m_instr", instr, m_instr);
         chk("m_instr_pc", instr_pc, m_ipc);
      end
      chk1("m_clk_en", fetch_clk_en, exp_en);
      if (instr_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual_pc=%h expected=none t=%0t", instr_pc, $time);
         end else begin
            chk("sb_pc", instr_pc, exp_q.pop_front());
         end
      end
      prev_valid = instr_valid;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         check_all();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_values();
      chk("rst_pc", pc, RST_PC);
      chk1("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      chk1("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk1("rst_clk_en", fetch_clk_en, 1'b0);
   endtask

   // From a REQ cycle: grant one cycle late, respond one cycle after grant,
   // and end at the first HOLD cycle.
   task automatic fetch_to_hold(input logic [AW-1:0] a, input logic [31:0] d);
      chk1("req_on", imem_req, 1'b1);
      chk("req_addr", imem_addr, a);
      imem_gnt = 0;
      tick();
      chk("req_addr_stable", imem_addr, a);
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      chk1("wait_req_off", imem_req, 1'b0);
      imem_rvalid = 1;
      imem_rdata  = d;
      tick();
      imem_rvalid = 0;
      imem_rdata  = '0;
      chk1("hold_valid", instr_valid, 1'b1);
      chk("hold_instr", instr, d);
      chk("hold_instr_pc", instr_pc, a);
   endtask

   task automatic drive_random();
      stall         = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 9) == 0);
      jal_taken     = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      jal_target    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      imem_gnt      = imem_req && ($urandom_range(0, 2) != 0);
      grant_addr    = imem_addr;
      if (mem_busy && mem_delay <= 0) begin
         imem_rvalid = 1;
         imem_rdata  = mem_word(mem_addr);
      end else begin
         imem_rvalid = 0;
         imem_rdata  = $urandom;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset_n = 0; stall = 0; branch_taken = 0; jal_taken = 0;
      branch_target = '0; jal_target = '0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; grant_addr = '0; mem_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1 check_reset_values();
      @(negedge clk);
      reset_n = 1;
      #1;
      chk1("boot_req", imem_req, 1'b0);
      chk1("boot_clk_en", fetch_clk_en, 1'b0);
      tick();

      // Sequential fetches 0, 4, 8 with no stall.
      fetch_to_hold(32'h0, 32'h0000_0093);
      tick();
      fetch_to_hold(32'h4, 32'h0010_0113);
      tick();
      fetch_to_hold(32'h8, 32'h0020_0193);
      tick();

      // Held instruction under stall.
      fetch_to_hold(32'hC, 32'hDEAD_BEEF);
      stall = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk1("stall_valid", instr_valid, 1'b1);
         chk("stall_instr", instr, 32'hDEAD_BEEF);
         chk("stall_pc", pc, 32'hC);
         chk1("stall_clk_en", fetch_clk_en, 1'b0);
         tick();
      end
      stall = 0;
      #1 chk1("unstall_clk_en", fetch_clk_en, 1'b1);
      tick();

      // Branch while waiting; the late response is killed.
      chk("kill_req_addr", imem_addr, 32'h10);
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      branch_taken = 1; branch_target = 32'h100;
      tick();
      branch_taken = 0;
      chk1("kill_wait_req", imem_req, 1'b0);
      tick();
      imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_rvalid = 0;
      chk1("kill_no_valid", instr_valid, 1'b0);
      chk1("kill_req", imem_req, 1'b1);
      chk("kill_next_addr", imem_addr, 32'h100);

      // Branch and JAL together in HOLD; branch wins, held instruction dropped.
      fetch_to_hold(32'h100, 32'h1111_2222);
      stall = 1; branch_taken = 1; branch_target = 32'h200; jal_taken = 1; jal_target = 32'h300;
      #1 chk1("redir_hold_clk_en", fetch_clk_en, 1'b1);
      tick();
      stall = 0; branch_taken = 0; jal_taken = 0;
      chk1("prio_dropped", instr_valid, 1'b0);
      chk1("prio_req", imem_req, 1'b1);
      chk("prio_addr", imem_addr, 32'h200);

      // JAL in REQ without grant, then wrap past all-ones.
      jal_taken = 1; jal_target = 32'hFFFF_FFFC;
      tick();
      jal_taken = 0;
      chk("jal_req_addr", imem_addr, 32'hFFFF_FFFC);
      fetch_to_hold(32'hFFFF_FFFC, 32'h0000_006F);
      tick();
      chk1("wrap_req", imem_req, 1'b1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc", pc, 32'h0);

      // Reset during WAIT; stray response after release is ignored.
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      chk1("pre_rst_wait", imem_req, 1'b0);
      reset_n = 0;
      model_reset();
      #1 check_reset_values();
      tick();
      reset_n = 1;
      imem_rvalid = 1; imem_rdata = 32'hBADB_AD00;
      #1;
      chk1("rst_boot_req", imem_req, 1'b0);
      tick();
      chk1("rst_first_req", imem_req, 1'b1);
      chk("rst_first_addr", imem_addr, RST_PC);
      chk1("rst_stray_ignored", instr_valid, 1'b0);
      tick();
      imem_rvalid = 0;
      chk1("rst_stray_ignored2", instr_valid, 1'b0);
      fetch_to_hold(RST_PC, 32'h0000_0513);
      tick();

      // Randomized phase.
      rand_mode = 1;
      mem_busy  = 0;
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         tick();
      end
      stall = 0; branch_taken = 0; jal_taken = 0; imem_gnt = 0; imem_rvalid = 0;
      #5;
      chk1("rand_progress", consumed > 100, 1'b1);
      chk("sb_leftover", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
